// File: rtl/seq_divider_8bit.sv
// Sequential signed restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, then a sign/saturation fix-up cycle.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 dbz,
  output logic                 ovf
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    acc;        // dividend magnitude shifts out, quotient bits shift in
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_lo;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r, zero;

  logic [DW-1:0]    dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH+1:0] shifted, trial;
  logic [WIDTH-1:0] q_neg, r_fix, q_fix;
  logic             ovf_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? FIX : DIV;
      DIV: begin
        busy = 1'b1;
        if (cnt == CW'(DW - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dvd_abs = dividend[DW-1] ? -dividend : dividend;
    dvs_abs = divisor[WIDTH-1] ? -divisor : divisor;
    shifted = {prem, acc[DW-1]};
    trial   = shifted - {2'b00, dvs_mag};
    q_neg   = -acc[WIDTH-1:0];
    r_fix   = sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    // Negative results may reach one further than positive ones (-128 vs 127).
    ovf_fix = sign_q ? (acc > DW'(2 ** (WIDTH - 1))) : (acc > DW'(2 ** (WIDTH - 1) - 1));
    if (ovf_fix) q_fix = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         q_fix = sign_q ? q_neg : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      prem      <= '0;
      dvs_mag   <= '0;
      dvd_lo    <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc     <= dvd_abs;
          dvs_mag <= dvs_abs;
          dvd_lo  <= dividend[WIDTH-1:0];
          sign_q  <= dividend[DW-1] ^ divisor[WIDTH-1];
          sign_r  <= dividend[DW-1];
          zero    <= (divisor == '0);
          prem    <= '0;
          cnt     <= '0;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH+1]) begin
            prem <= trial[WIDTH:0];
            acc  <= {acc[DW-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH:0];
            acc  <= {acc[DW-2:0], 1'b0};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (zero) begin
            dbz       <= 1'b1;
            ovf       <= 1'b0;
            quotient  <= '1;
            remainder <= dvd_lo;
          end else begin
            dbz       <= 1'b0;
            ovf       <= ovf_fix;
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed and randomized checks of seq_divider_8bit: results, flags, latency,
// handshake behaviour and synchronous reset.
module tb_seq_divider_8bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, dbz, ovf;
  logic [7:0]  quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and returns capture-to-done latency and busy cycle count.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output int lat, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf, input int elat);
    int lat, bcnt;
    do_op(a, b, lat, bcnt);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy_cycles"}, bcnt, elat);
    chk({tag, " busy_in_done"}, busy, 1'b0);
    chk({tag, " q"}, quotient, eq);
    chk({tag, " r"}, remainder, er);
    chk({tag, " dbz"}, dbz, edbz);
    chk({tag, " ovf"}, ovf, eovf);
    tick();
    chk({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat, bcnt, t_first, k;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset q", quotient, 8'h00);
    chk("reset r", remainder, 8'h00);
    chk("reset flags", {dbz, ovf}, 2'b00);
    rst = 1'b0;
    tick();

    directed("100/7",       16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 17);
    directed("-100/7",      16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 17);
    directed("100/-7",      16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 17);
    directed("-100/-7",     16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 17);
    directed("16384/-128",  16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 17);
    directed("-16384/-128", 16'hC000, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b1, 17);
    directed("16384/127",   16'h4000, 8'h7F, 8'h7F, 8'h01, 1'b0, 1'b1, 17);
    directed("-32768/-128", 16'h8000, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b1, 17);
    directed("-32768/1",    16'h8000, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 17);
    directed("-129/128neg", 16'hFF7F, 8'h80, 8'h01, 8'hFF, 1'b0, 1'b0, 17);
    directed("dbz",         16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1);

    // Reset in the middle of DIV discards the operation.
    dividend = 16'h0064; divisor = 8'h07; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst q/r", {quotient, remainder}, 16'h0000);
    chk("midrst flags", {dbz, ovf}, 2'b00);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) k++;
    end
    chk("midrst no_done", k, 0);
    directed("post-rst 100/7", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 17);

    // A start pulse during DIV with other operands must be ignored.
    dividend = 16'hFF9C; divisor = 8'hF9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    dividend = 16'h1234; divisor = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 6;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("ignored_start latency", lat, 17);
    chk("ignored_start q", quotient, 8'h0E);
    chk("ignored_start r", remainder, 8'hFE);
    tick();
    chk("ignored_start no_second", {busy, done}, 2'b00);

    // Start asserted in the done cycle is accepted; dones are 18 cycles apart.
    do_op(16'h0064, 8'h07, lat, bcnt);
    chk("b2b first done", done, 1'b1);
    t_first = cyc;
    do_op(16'h0064, 8'hF9, lat, bcnt);
    chk("b2b second done", done, 1'b1);
    chk("b2b spacing", cyc - t_first, 18);
    chk("b2b second q", quotient, 8'hF2);
    tick();

    // Random sweep against an integer reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [7:0]  b, eq, er;
      int sa, sb, q, r;
      logic        eovf;
      b = 8'($urandom);
      if (i % 3 == 0) begin
        a = 16'($urandom);
      end else begin
        a = 16'($signed(b) * $signed(8'($urandom)) + $signed(8'($urandom_range(0, 15))));
      end
      if (i % 97 == 0) b = 8'h00;
      sa = int'($signed(a));
      sb = int'($signed(b));
      do_op(a, b, lat, bcnt);
      if (sb == 0) begin
        chk("rnd dbz lat", lat, 1);
        chk("rnd dbz flags", {dbz, ovf}, 2'b10);
        chk("rnd dbz q/r", {quotient, remainder}, {8'hFF, a[7:0]});
      end else begin
        q = sa / sb;
        r = sa % sb;
        eovf = (q > 127) || (q < -128);
        eq = eovf ? ((q > 0) ? 8'h7F : 8'h80) : q[7:0];
        er = r[7:0];
        chk("rnd lat", lat, 17);
        chk("rnd flags", {dbz, ovf}, {1'b0, eovf});
        chk("rnd q", quotient, eq);
        chk("rnd r", remainder, er);
        if (!eovf)
          chk("rnd invariant", sa, int'($signed(quotient)) * sb + int'($signed(remainder)));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
